vga_timing_pipe: RTL

Parametrised VGA raster generator. It replaces the fixed 1-bit, zero-latency controller. It drives sync and colour pins for any `vga_pkg::vga_params_t` mode, with multi-bit colour. Sync and blanking are delayed to match a renderer pipeline of configurable depth. It also provides frame/line strobes and a vblank-aligned double-buffer swap handshake. The PLL is outside this block; `vga_clk` arrives already locked and global.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_delay_line.sv | 32 +++
 rtl/vga_timing_pipe.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing types, mode presets and helpers for the raster pipeline.
package vga_pkg;

   typedef struct packed {
      int unsigned h_visible;
      int unsigned h_front;
      int unsigned h_sync;
      int unsigned h_back;
      int unsigned v_visible;
      int unsigned v_front;
      int unsigned v_sync;
      int unsigned v_back;
      logic        h_sync_pol;  // 1 = active-high pulse
      logic        v_sync_pol;
   } vga_params_t;

   localparam vga_params_t VGA_640x480_60 = '{
      h_visible: 640, h_front: 16, h_sync: 96, h_back: 48,
      v_visible: 480, v_front: 10, v_sync: 2,  v_back: 33,
      h_sync_pol: 1'b0, v_sync_pol: 1'b0
   };

   localparam vga_params_t VGA_800x600_60 = '{
      h_visible: 800, h_front: 40, h_sync: 128, h_back: 88,
      v_visible: 600, v_front: 1,  v_sync: 4,   v_back: 23,
      h_sync_pol: 1'b1, v_sync_pol: 1'b1
   };

   localparam int unsigned MAX_LATENCY = 8;

   function automatic int unsigned h_total(vga_params_t p);
      return p.h_visible + p.h_front + p.h_sync + p.h_back;
   endfunction

   function automatic int unsigned v_total(vga_params_t p);
      return p.v_visible + p.v_front + p.v_sync + p.v_back;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with synchronous reset; DEPTH of 0 is a plain wire.
module vga_delay_line #(
   parameter int unsigned       WIDTH     = 1,
   parameter int unsigned       DEPTH     = 1,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ reset_i;
      assign data_o = data_i;
   end else begin : g_regs
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RESET_VAL;
         end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign data_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA raster generator: coordinate requests, renderer-latency-matched
// sync/blanking, frame/line strobes and a vblank-aligned buffer swap handshake.
module vga_timing_pipe
   import vga_pkg::*;
#(
   parameter vga_params_t params  = VGA_640x480_60,
   parameter int unsigned COLOR_W = 1,
   parameter int unsigned LATENCY = 1,
   localparam int unsigned XW = $clog2(params.h_visible),
   localparam int unsigned YW = $clog2(params.v_visible)
) (
   input  logic               vga_clk,
   input  logic               reset,
   output logic [XW-1:0]      pixel_x_target_next,
   output logic [YW-1:0]      pixel_y_target_next,
   output logic               pixel_req_valid,
   input  logic [COLOR_W-1:0] pixel_value_next,
   output logic               frame_start,
   output logic               line_start,
   output logic               vblank,
   input  logic               swap_req,
   output logic               swap_ack,
   output logic               buffer_sel,
   output logic               h_sync,
   output logic               v_sync,
   output logic [COLOR_W-1:0] pixel_signal
);

   localparam int unsigned HTotal = h_total(params);
   localparam int unsigned VTotal = v_total(params);
   localparam int unsigned HW     = $clog2(HTotal);
   localparam int unsigned VW     = $clog2(VTotal);

   localparam logic [HW-1:0] HLast     = HW'(HTotal - 1);
   localparam logic [HW-1:0] HVis      = HW'(params.h_visible);
   localparam logic [HW-1:0] HSyncBeg  = HW'(params.h_visible + params.h_front);
   // One extra bit so a zero back porch does not wrap the window end to 0.
   localparam logic [HW:0]   HSyncEnd  = (HW+1)'(params.h_visible + params.h_front
                                                  + params.h_sync);
   localparam logic [VW-1:0] VLast     = VW'(VTotal - 1);
   localparam logic [VW-1:0] VVis      = VW'(params.v_visible);
   localparam logic [VW-1:0] VSyncBeg  = VW'(params.v_visible + params.v_front);
   localparam logic [VW:0]   VSyncEnd  = (VW+1)'(params.v_visible + params.v_front
                                                  + params.v_sync);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;

   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == HLast) begin
         h_d = '0;
         v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   // Request stage, straight from the counters.
   logic h_vis, v_vis, hs_pulse, vs_pulse, swap_take;

   assign h_vis    = h_q < HVis;
   assign v_vis    = v_q < VVis;
   assign hs_pulse = (h_q >= HSyncBeg) && ({1'b0, h_q} < HSyncEnd);
   assign vs_pulse = (v_q >= VSyncBeg) && ({1'b0, v_q} < VSyncEnd);

   assign pixel_req_valid     = h_vis && v_vis;
   assign pixel_x_target_next = pixel_req_valid ? h_q[XW-1:0] : '0;
   assign pixel_y_target_next = pixel_req_valid ? v_q[YW-1:0] : '0;
   assign frame_start         = (h_q == '0) && (v_q == '0);
   assign line_start          = (h_q == '0) && v_vis;
   assign vblank              = !v_vis;
   assign swap_take           = swap_req && (h_q == '0) && (v_q == VVis);

   logic [2:0] req_bits, dly_bits;

   assign req_bits = {hs_pulse, vs_pulse, pixel_req_valid};

   vga_delay_line #(
      .WIDTH     (3),
      .DEPTH     (LATENCY),
      .RESET_VAL (3'b000)
   ) u_delay (
      .clk_i   (vga_clk),
      .reset_i (reset),
      .data_i  (req_bits),
      .data_o  (dly_bits)
   );

   logic               h_sync_q, h_sync_d;
   logic               v_sync_q, v_sync_d;
   logic [COLOR_W-1:0] pixel_q, pixel_d;
   logic               swap_ack_q, swap_ack_d;
   logic               buffer_sel_q, buffer_sel_d;

   always_comb begin
      h_sync_d     = dly_bits[2] ? params.h_sync_pol : ~params.h_sync_pol;
      v_sync_d     = dly_bits[1] ? params.v_sync_pol : ~params.v_sync_pol;
      pixel_d      = dly_bits[0] ? pixel_value_next : '0;
      swap_ack_d   = swap_take;
      buffer_sel_d = buffer_sel_q ^ swap_take;
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         h_sync_q     <= ~params.h_sync_pol;
         v_sync_q     <= ~params.v_sync_pol;
         pixel_q      <= '0;
         swap_ack_q   <= 1'b0;
         buffer_sel_q <= 1'b0;
      end else begin
         h_sync_q     <= h_sync_d;
         v_sync_q     <= v_sync_d;
         pixel_q      <= pixel_d;
         swap_ack_q   <= swap_ack_d;
         buffer_sel_q <= buffer_sel_d;
      end
   end

   assign h_sync       = h_sync_q;
   assign v_sync       = v_sync_q;
   assign pixel_signal = pixel_q;
   assign swap_ack     = swap_ack_q;
   assign buffer_sel   = buffer_sel_q;

endmodule
